// File: rtl/tree_node_pkg.sv
// Shared types and helpers for the tree_node_dispatch hierarchy node.
package tree_node_pkg;

  // Widest lane count a node may be built with; pointers and request
  // vectors are padded to this width inside the round-robin helper.
  localparam int MAX_CH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lane_st_e;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, searching upward and wrapping
  // at n. Used both to pick an idle lane for dispatch and a done lane
  // for collection, so the two arbiters behave identically.
  function automatic rr_pick_t rr_first(input logic [MAX_CH-1:0] req,
                                        input logic [3:0]        ptr,
                                        input int                n);
    rr_pick_t pick;
    int       j;
    pick.found = 1'b0;
    pick.idx   = 4'd0;
    for (int k = 0; k < MAX_CH; k++) begin
      j = int'(ptr) + k;
      j = (j >= n) ? (j - n) : j;
      if ((k < n) && !pick.found && req[j[3:0]]) begin
        pick.found = 1'b1;
        pick.idx   = j[3:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tree_node_dispatch_lane.sv
// One child worker lane: IDLE -> RUN (countdown) -> DONE (hold result).
module tree_node_lane
  import tree_node_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] start_data,
  input  logic [CNT_W-1:0]  start_cycles,
  input  logic              collect,
  output lane_st_e          state,
  output logic [DATA_W-1:0] result
);

  lane_st_e          state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] result_r;
  logic [CNT_W-1:0]  eff_cycles_s;

  // A zero budget is run as a one-cycle budget.
  always_comb begin
    if (start_cycles == {CNT_W{1'b0}}) begin
      eff_cycles_s = {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      eff_cycles_s = start_cycles;
    end
  end

  // Lane state machine, countdown and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      result_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r  <= RUN;
            cnt_r    <= eff_cycles_s;
            // Result is fixed at dispatch; it wraps modulo 2^DATA_W.
            result_r <= start_data + DATA_W'(eff_cycles_s);
          end
        end
        RUN: begin
          cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          if (collect) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign state  = state_r;
  assign result = result_r;

endmodule

// File: rtl/tree_node_dispatch.sv
// Hierarchy node: round-robin fan-out of work items to NUM_CH lanes and
// round-robin fan-in of their results onto one registered output.
module tree_node_dispatch
  import tree_node_pkg::*;
#(
  parameter  int NUM_CH = 5,
  parameter  int DATA_W = 16,
  parameter  int CNT_W  = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_cycles,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [NUM_CH-1:0] busy_mask
);

  lane_st_e          lane_st_s  [NUM_CH];
  logic [DATA_W-1:0] lane_res_s [NUM_CH];

  logic [NUM_CH-1:0] idle_s;
  logic [NUM_CH-1:0] done_s;
  logic [NUM_CH-1:0] start_s;
  logic [NUM_CH-1:0] collect_s;

  logic [CH_W-1:0]   disp_ptr_r;
  logic [CH_W-1:0]   coll_ptr_r;
  rr_pick_t          disp_pick_s;
  rr_pick_t          coll_pick_s;
  logic [CH_W-1:0]   disp_idx_s;
  logic [CH_W-1:0]   coll_idx_s;
  logic              dispatch_s;
  logic              load_out_s;
  logic              take_s;

  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [CH_W-1:0]   out_ch_r;

  // Round-robin pointer advance: one past the winner, wrapping at NUM_CH.
  function automatic logic [CH_W-1:0] ptr_next(input logic [CH_W-1:0] p);
    if (p == CH_W'(NUM_CH - 1)) begin
      return {CH_W{1'b0}};
    end else begin
      return p + {{(CH_W-1){1'b0}}, 1'b1};
    end
  endfunction

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_lane
      tree_node_lane #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
      ) u_lane (
        .clk          (clk),
        .rst          (rst),
        .start        (start_s[g]),
        .start_data   (in_data),
        .start_cycles (in_cycles),
        .collect      (collect_s[g]),
        .state        (lane_st_s[g]),
        .result       (lane_res_s[g])
      );
    end
  endgenerate

  // Per-lane idle/done flags decoded from the registered lane states.
  always_comb begin
    idle_s = {NUM_CH{1'b0}};
    done_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      idle_s[i] = (lane_st_s[i] == IDLE);
      done_s[i] = (lane_st_s[i] == DONE);
    end
  end

  assign in_ready  = |idle_s;
  assign busy_mask = ~idle_s;

  // Dispatch and collect arbitration; the two act on disjoint lanes
  // (IDLE vs DONE) so they never interfere within a cycle.
  always_comb begin
    disp_pick_s = rr_first(MAX_CH'(idle_s), 4'(disp_ptr_r), NUM_CH);
    coll_pick_s = rr_first(MAX_CH'(done_s), 4'(coll_ptr_r), NUM_CH);
    disp_idx_s  = disp_pick_s.idx[CH_W-1:0];
    coll_idx_s  = coll_pick_s.idx[CH_W-1:0];
    dispatch_s  = in_valid && in_ready && disp_pick_s.found;
    load_out_s  = !out_valid_r || out_ready;
    take_s      = load_out_s && coll_pick_s.found;
    start_s     = {NUM_CH{1'b0}};
    collect_s   = {NUM_CH{1'b0}};
    if (dispatch_s) begin
      start_s[disp_idx_s] = 1'b1;
    end else begin
      start_s = {NUM_CH{1'b0}};
    end
    if (take_s) begin
      collect_s[coll_idx_s] = 1'b1;
    end else begin
      collect_s = {NUM_CH{1'b0}};
    end
  end

  // Round-robin pointers for dispatch and collection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_ptr_r <= {CH_W{1'b0}};
      coll_ptr_r <= {CH_W{1'b0}};
    end else begin
      if (dispatch_s) begin
        disp_ptr_r <= ptr_next(disp_idx_s);
      end
      if (take_s) begin
        coll_ptr_r <= ptr_next(coll_idx_s);
      end
    end
  end

  // Output register: reloads when empty or when the held result drains,
  // giving one result per cycle under continuous out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_ch_r    <= {CH_W{1'b0}};
    end else if (load_out_s) begin
      out_valid_r <= coll_pick_s.found;
      if (coll_pick_s.found) begin
        out_data_r <= lane_res_s[coll_idx_s];
        out_ch_r   <= coll_idx_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_tree_node_dispatch.sv
// Directed self-checking bench for tree_node_dispatch (NUM_CH=5).
module tb_tree_node_dispatch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [7:0]  in_cycles;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_ch;
  logic [4:0]  busy_mask;

  int n_checks;
  int n_fail;

  tree_node_dispatch #(
    .NUM_CH (5),
    .DATA_W (16),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cycles (in_cycles),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .busy_mask (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [7:0] c);
    check_eq("in_ready_at_send", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_cycles = c;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int k;
    int seen;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_cycles = 8'd0;
    out_ready = 1'b1;
    step();
    step();
    // Reset state
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {16'd0, out_data}, 32'h0);
    check_eq("rst_out_ch", {29'd0, out_ch}, 32'd0);
    check_eq("rst_busy", {27'd0, busy_mask}, 32'h00);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    step();

    // Single item, budget 3 -> lane 0, latency 4
    send(16'h0010, 8'd3);
    check_eq("single_busy", {27'd0, busy_mask}, 32'h01);
    step();
    step();
    step();
    check_eq("single_not_yet", {31'd0, out_valid}, 32'd0);
    step();
    check_eq("single_valid", {31'd0, out_valid}, 32'd1);
    check_eq("single_data", {16'd0, out_data}, 32'h0013);
    check_eq("single_ch", {29'd0, out_ch}, 32'd0);
    step();
    check_eq("single_drained", {31'd0, out_valid}, 32'd0);
    check_eq("single_idle", {27'd0, busy_mask}, 32'h00);

    // Zero budget with data wrap -> lane 1, latency 2
    send(16'hFFFF, 8'd0);
    step();
    check_eq("zero_not_yet", {31'd0, out_valid}, 32'd0);
    step();
    check_eq("zero_valid", {31'd0, out_valid}, 32'd1);
    check_eq("zero_data", {16'd0, out_data}, 32'h0000);
    check_eq("zero_ch", {29'd0, out_ch}, 32'd1);
    step();

    // Fill all lanes, sixth item waits for the first collect
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(16'(i * 256), 8'd20);
      check_eq("fill_busy", {27'd0, busy_mask}, 32'((1 << (i + 1)) - 1));
    end
    check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid  = 1'b1;
    in_data   = 16'h0555;
    in_cycles = 8'd2;
    k = 0;
    while (!in_ready && k < 40) begin
      step();
      k++;
    end
    check_eq("sixth_wait", 32'(k), 32'd17);
    check_eq("first_out_ch", {29'd0, out_ch}, 32'd0);
    check_eq("first_out_data", {16'd0, out_data}, 32'h0014);
    step();
    in_valid = 1'b0;
    check_eq("sixth_busy", {27'd0, busy_mask}, 32'h1D);
    check_eq("drain_ch1", {29'd0, out_ch}, 32'd1);
    check_eq("drain_d1", {16'd0, out_data}, 32'h0114);
    step();
    check_eq("drain_ch2", {29'd0, out_ch}, 32'd2);
    check_eq("drain_d2", {16'd0, out_data}, 32'h0214);
    step();
    check_eq("drain_ch3", {29'd0, out_ch}, 32'd3);
    check_eq("drain_d3", {16'd0, out_data}, 32'h0314);
    step();
    check_eq("drain_ch4", {29'd0, out_ch}, 32'd4);
    check_eq("drain_d4", {16'd0, out_data}, 32'h0414);
    step();
    check_eq("drain_ch0", {29'd0, out_ch}, 32'd0);
    check_eq("drain_d0", {16'd0, out_data}, 32'h0557);
    check_eq("drain_v0", {31'd0, out_valid}, 32'd1);
    step();
    check_eq("drain_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    send(16'h0020, 8'd1);
    send(16'h0021, 8'd1);
    send(16'h0022, 8'd1);
    check_eq("bp_valid0", {31'd0, out_valid}, 32'd1);
    check_eq("bp_data0", {16'd0, out_data}, 32'h0021);
    step();
    step();
    step();
    check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check_eq("bp_hold_data", {16'd0, out_data}, 32'h0021);
    check_eq("bp_hold_ch", {29'd0, out_ch}, 32'd0);
    check_eq("bp_busy", {27'd0, busy_mask}, 32'h06);
    out_ready = 1'b1;
    step();
    check_eq("bp_ch1", {29'd0, out_ch}, 32'd1);
    check_eq("bp_d1", {16'd0, out_data}, 32'h0022);
    check_eq("bp_v1", {31'd0, out_valid}, 32'd1);
    step();
    check_eq("bp_ch2", {29'd0, out_ch}, 32'd2);
    check_eq("bp_d2", {16'd0, out_data}, 32'h0023);
    check_eq("bp_v2", {31'd0, out_valid}, 32'd1);
    step();
    check_eq("bp_empty", {31'd0, out_valid}, 32'd0);

    // Round-robin fairness: next item skips free lane 0
    do_reset();
    send(16'h0030, 8'd1);
    send(16'h0031, 8'd5);
    send(16'h0032, 8'd1);
    send(16'h0033, 8'd4);
    check_eq("rr_busy", {27'd0, busy_mask}, 32'h0E);
    for (int i = 0; i < 12; i++) step();
    check_eq("rr_settled", {27'd0, busy_mask}, 32'h00);

    // Reset mid-run drops everything
    do_reset();
    out_ready = 1'b0;
    send(16'h0040, 8'd1);
    send(16'h0041, 8'd10);
    send(16'h0042, 8'd10);
    send(16'h0043, 8'd10);
    check_eq("mr_pre_valid", {31'd0, out_valid}, 32'd1);
    check_eq("mr_pre_busy", {27'd0, busy_mask}, 32'h0E);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mr_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mr_data", {16'd0, out_data}, 32'h0);
    check_eq("mr_ch", {29'd0, out_ch}, 32'd0);
    check_eq("mr_busy", {27'd0, busy_mask}, 32'h00);
    check_eq("mr_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) seen++;
    end
    check_eq("mr_no_stale", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
